// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 receiver: deserialises device-to-host frames and holds o1/o2 while mapped keys are down.
// Optional PS2_NUMPAD_EN: keypad-1 (8'h69) / keypad-2 (8'h72) also drive o1 / o2.
module ps2_key_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter logic [7:0]  CODE_1         = 8'h16,
    parameter logic [7:0]  CODE_2         = 8'h1E
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iPs2Clk,
    input  logic       iPs2Dat,
    output logic       o1,
    output logic       o2,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oFrameErr
);
    localparam int unsigned   TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TW-1:0]          r_timeout;
    state_e                 r_state;
    logic                   r_key1;
    logic                   r_key2;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;
    logic w_good;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;
    // Only meaningful while the stop bit is being sampled.
    assign w_good  = (^{r_shift, r_par}) & w_dat_s;

`ifdef PS2_NUMPAD_EN
    localparam logic [7:0] KP_1 = 8'h69;
    localparam logic [7:0] KP_2 = 8'h72;

    logic r_kp1;
    logic r_kp2;

    assign o1 = r_key1 | r_kp1;
    assign o2 = r_key2 | r_kp2;
`else
    assign o1 = r_key1;
    assign o2 = r_key2;
`endif

    always_ff @(posedge clk) begin
        if (iReset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_timeout  <= '0;
            r_state    <= StIdle;
            r_key1     <= 1'b0;
            r_key2     <= 1'b0;
`ifdef PS2_NUMPAD_EN
            r_kp1      <= 1'b0;
            r_kp2      <= 1'b0;
`endif
            oScanCode  <= '0;
            oScanValid <= 1'b0;
            oFrameErr  <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], iPs2Clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], iPs2Dat};
            r_clk_prev <= w_clk_s;
            oScanValid <= 1'b0;
            oFrameErr  <= 1'b0;

            if (w_fall) begin
                r_timeout <= '0;
                if (r_bit_cnt == 4'd0) begin
                    if (!w_dat_s) r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {w_dat_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par     <= w_dat_s;
                    r_bit_cnt <= 4'd10;
                end else begin
                    r_bit_cnt <= 4'd0;
                    if (w_good) begin
                        oScanCode  <= r_shift;
                        oScanValid <= 1'b1;
                        case (r_state)
                            StIdle: begin
                                if (r_shift == 8'hF0) r_state <= StBreak;
                                else if (r_shift == 8'hE0) r_state <= StExt;
                                else if (r_shift == CODE_1) r_key1 <= 1'b1;
                                else if (r_shift == CODE_2) r_key2 <= 1'b1;
`ifdef PS2_NUMPAD_EN
                                else if (r_shift == KP_1) r_kp1 <= 1'b1;
                                else if (r_shift == KP_2) r_kp2 <= 1'b1;
`endif
                            end
                            StBreak: begin
                                if (r_shift == CODE_1) r_key1 <= 1'b0;
                                else if (r_shift == CODE_2) r_key2 <= 1'b0;
`ifdef PS2_NUMPAD_EN
                                else if (r_shift == KP_1) r_kp1 <= 1'b0;
                                else if (r_shift == KP_2) r_kp2 <= 1'b0;
`endif
                                r_state <= StIdle;
                            end
                            StExt:   r_state <= (r_shift == 8'hF0) ? StExtBreak : StIdle;
                            default: r_state <= StIdle;
                        endcase
                    end else begin
                        oFrameErr <= 1'b1;
                    end
                end
            end else if (r_bit_cnt != 4'd0) begin
                // Abandon a partial frame once the line has been quiet too long.
                if (r_timeout == TIMEOUT_MAX) begin
                    r_bit_cnt <= 4'd0;
                    r_timeout <= '0;
                end else begin
                    r_timeout <= r_timeout + 1'b1;
                end
            end else begin
                r_timeout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table of frames plus scoreboard of expected bytes.
module tb_ps2_key_decoder;
    localparam int HALF = 20;  // PS/2 half period in clk cycles
    localparam int LAT  = 3;   // raw stop-bit fall to registered pulse: 2 sync flops + 1

    logic       clk = 1'b0;
    logic       iReset = 1'b1;
    logic       iPs2Clk = 1'b1;
    logic       iPs2Dat = 1'b1;
    logic       o1, o2, oScanValid, oFrameErr;
    logic [7:0] oScanCode;

    always #5 clk = ~clk;

    ps2_key_decoder dut (
        .clk       (clk),
        .iReset    (iReset),
        .iPs2Clk   (iPs2Clk),
        .iPs2Dat   (iPs2Dat),
        .o1        (o1),
        .o2        (o2),
        .oScanCode (oScanCode),
        .oScanValid(oScanValid),
        .oFrameErr (oFrameErr)
    );

    typedef struct {
        logic [7:0] code;
        logic       o1;
        logic       o2;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        logic       o1;
        logic       o2;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         stop_cyc = 0;
    int         exp_err = 0;
    int         seen_err = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (oScanValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got code %0h, expected no pulse", oScanCode);
                end else begin
                    e = exp_q.pop_front();
                    check("scan_code", oScanCode, e.code);
                    check("o1_at_valid", o1, e.o1);
                    check("o2_at_valid", o2, e.o2);
                    check("valid_latency", cyc - stop_cyc, LAT);
                end
            end
            if (oFrameErr) begin
                seen_err++;
                check("err_latency", cyc - stop_cyc, LAT);
            end
        end
    endtask

    task automatic ps2_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            iPs2Dat = f[i];
            ps2_wait(HALF);
            iPs2Clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            ps2_wait(HALF);
            iPs2Clk = 1'b1;
        end
        iPs2Dat = 1'b1;
        ps2_wait(2 * HALF);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        if (v.bad_par || v.bad_stop) begin
            exp_err++;
        end else begin
            e.code = v.code;
            e.o1 = v.o1;
            e.o2 = v.o2;
            exp_q.push_back(e);
            last_good = v.code;
        end
        send_bits(v.code, v.bad_par, v.bad_stop, 11);
        check("queue_drained", exp_q.size(), 0);
        check("frame_errs", seen_err, exp_err);
        check("o1_level", o1, v.o1);
        check("o2_level", o2, v.o2);
        check("scan_hold", oScanCode, last_good);
    endtask

    task automatic add(input logic [7:0] code, input bit bp, input bit bs,
                       input logic e1, input logic e2);
        vec_t v;
        v.code = code;
        v.bad_par = bp;
        v.bad_stop = bs;
        v.o1 = e1;
        v.o2 = e2;
        vecs.push_back(v);
    endtask

    function automatic vec_t mk(input logic [7:0] code, input logic e1, input logic e2);
        vec_t v;
        v.code = code;
        v.bad_par = 1'b0;
        v.bad_stop = 1'b0;
        v.o1 = e1;
        v.o2 = e2;
        return v;
    endfunction

    initial begin
        // Key-1 make/release, both keys held, extended-break interlock, typematic.
        add(8'h16, 0, 0, 1, 0); add(8'hF0, 0, 0, 1, 0); add(8'h16, 0, 0, 0, 0);
        add(8'h16, 0, 0, 1, 0); add(8'h1E, 0, 0, 1, 1); add(8'hE0, 0, 0, 1, 1);
        add(8'hF0, 0, 0, 1, 1); add(8'h16, 0, 0, 1, 1); add(8'h16, 0, 0, 1, 1);
        add(8'hF0, 0, 0, 1, 1); add(8'h1E, 0, 0, 1, 0); add(8'hF0, 0, 0, 1, 0);
        add(8'h16, 0, 0, 0, 0);
        // Bad parity / bad stop: dropped, FSM state untouched.
        add(8'h16, 1, 0, 0, 0); add(8'h1E, 0, 1, 0, 0);
        add(8'h16, 0, 0, 1, 0); add(8'hF0, 0, 0, 1, 0); add(8'h1E, 1, 0, 1, 0);
        add(8'h16, 0, 0, 0, 0);
        // Extended make of a mapped code is ignored.
        add(8'hE0, 0, 0, 0, 0); add(8'h16, 0, 0, 0, 0);
`ifdef PS2_NUMPAD_EN
        add(8'h16, 0, 0, 1, 0); add(8'h69, 0, 0, 1, 0); add(8'hF0, 0, 0, 1, 0);
        add(8'h16, 0, 0, 1, 0); add(8'hF0, 0, 0, 1, 0); add(8'h69, 0, 0, 0, 0);
        add(8'h72, 0, 0, 0, 1); add(8'h1E, 0, 0, 0, 1); add(8'hF0, 0, 0, 0, 1);
        add(8'h72, 0, 0, 0, 1); add(8'hF0, 0, 0, 0, 1); add(8'h1E, 0, 0, 0, 0);
`else
        add(8'h69, 0, 0, 0, 0); add(8'h72, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0);
        add(8'h69, 0, 0, 0, 0);
`endif

        fork
            monitor();
        join_none

        // Reset state.
        ps2_wait(4);
        check("rst_o1", o1, 0);
        check("rst_o2", o2, 0);
        check("rst_code", oScanCode, 8'h00);
        check("rst_valid", oScanValid, 0);
        check("rst_err", oFrameErr, 0);
        iReset = 1'b0;
        ps2_wait(10);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Start bit sampled high is discarded; next frame must still align.
        iPs2Dat = 1'b1;
        ps2_wait(HALF);
        iPs2Clk = 1'b0;
        ps2_wait(HALF);
        iPs2Clk = 1'b1;
        ps2_wait(HALF);
        run_vec(mk(8'h1E, 0, 1));
        run_vec(mk(8'hF0, 0, 1));
        run_vec(mk(8'h1E, 0, 0));

        // Timeout: partial frame, long idle, then a full frame.
        send_bits(8'h16, 0, 0, 5);
        ps2_wait(30000);
        check("timeout_no_err", seen_err, exp_err);
        check("timeout_no_valid", exp_q.size(), 0);
        run_vec(mk(8'h1E, 0, 1));

        // Mid-frame reset after bit 6 of a 16 frame.
        send_bits(8'h16, 0, 0, 7);
        @(posedge clk);
        #1;
        iReset = 1'b1;
        ps2_wait(1);
        iReset = 1'b0;
        check("mrst_o1", o1, 0);
        check("mrst_o2", o2, 0);
        check("mrst_code", oScanCode, 8'h00);
        check("mrst_valid", oScanValid, 0);
        last_good = 8'h00;
        ps2_wait(2 * HALF);
        run_vec(mk(8'h1E, 0, 1));

        ps2_wait(20);
        check("final_queue", exp_q.size(), 0);
        check("final_errs", seen_err, exp_err);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
